// File: rtl/adc_pkg.sv
// adc_pkg: shared state type, widths and the millivolt scaling helper for adc_bcd_conv.
package adc_pkg;
  typedef enum logic [1:0] {ACC, SCALE, CONV, DONE} state_t;
  localparam int ADC_W = 8;
  localparam int MV_W = 12;
  localparam int BCD_W = 16;
  localparam int CONV_SHIFTS = MV_W;
  function automatic logic [MV_W-1:0] scale_mv(input logic [ADC_W-1:0] avg, input logic [MV_W-1:0] vref);
    logic [ADC_W+MV_W-1:0] p;
    p = {{MV_W{1'b0}}, avg} * {{ADC_W{1'b0}}, vref};
    return p[ADC_W+MV_W-1:ADC_W];
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: 12-bit sequential double-dabble; start loads bin, then one add-3/shift step per cycle.
module bin2bcd_seq import adc_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MV_W-1:0]  bin,
  output logic [BCD_W-1:0] bcd,
  output logic             done
);
  logic [BCD_W+MV_W-1:0] z, adj;
  logic [3:0] cnt;
  always_comb begin
    adj = z;
    for (int i = 0; i < BCD_W / 4; i++)
      adj[MV_W+4*i +: 4] = z[MV_W+4*i +: 4] >= 4'd5 ? z[MV_W+4*i +: 4] + 4'd3 : z[MV_W+4*i +: 4];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      z <= '0;
      cnt <= '0;
    end else if (start) begin
      z <= {{BCD_W{1'b0}}, bin};
      cnt <= 4'(CONV_SHIFTS);
    end else if (cnt != 4'd0) begin
      z <= adj << 1;
      cnt <= cnt - 4'd1;
    end
  end
  assign bcd = z[BCD_W+MV_W-1:MV_W];
  // high during the final shift so the caller can load the result on the next edge
  assign done = cnt == 4'd1;
endmodule

// File: rtl/adc_bcd_conv.sv
// adc_bcd_conv: ADC samples to millivolt BCD digits; define ADC_BCD_AVG_EN to average 2^AVG_LOG2 samples per window.
module adc_bcd_conv import adc_pkg::*; #(
  parameter int AVG_LOG2 = 2,
  parameter int VREF_MV = 3300
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADC_W-1:0] sample,
  input  logic             sample_valid,
  output logic [3:0]       led0,
  output logic [3:0]       led1,
  output logic [3:0]       led2,
  output logic [3:0]       led3,
  output logic             digits_valid,
  output logic             busy,
  output logic             overrun
);
  state_t state;
  logic [ADC_W-1:0] avg;
  logic [BCD_W-1:0] bcd;
  logic done;
  if (AVG_LOG2 < 1 || AVG_LOG2 > 4 || VREF_MV < 1 || VREF_MV > 4095) begin : g_bad_param
    $error("adc_bcd_conv: parameter out of range");
  end
`ifdef ADC_BCD_AVG_EN
  logic [ADC_W+AVG_LOG2-1:0] acc;
  logic [AVG_LOG2-1:0] cnt;
  assign avg = acc[ADC_W+AVG_LOG2-1:AVG_LOG2];
`endif
  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (state == SCALE),
    .bin   (scale_mv(avg, 12'(VREF_MV))),
    .bcd   (bcd),
    .done  (done)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
      {led3, led2, led1, led0} <= '0;
      digits_valid <= 1'b0;
      busy <= 1'b0;
      overrun <= 1'b0;
`ifdef ADC_BCD_AVG_EN
      acc <= '0;
      cnt <= '0;
`else
      avg <= '0;
`endif
    end else begin
      digits_valid <= 1'b0;
      overrun <= sample_valid && busy;
      case (state)
        ACC: if (sample_valid) begin
`ifdef ADC_BCD_AVG_EN
          acc <= acc + (ADC_W+AVG_LOG2)'(sample);
          cnt <= cnt + 1'b1;
          if (&cnt) begin
            state <= SCALE;
            busy <= 1'b1;
          end
`else
          avg <= sample;
          state <= SCALE;
          busy <= 1'b1;
`endif
        end
        SCALE: begin
          state <= CONV;
`ifdef ADC_BCD_AVG_EN
          acc <= '0;
          cnt <= '0;
`endif
        end
        CONV: if (done) state <= DONE;
        DONE: begin
          {led3, led2, led1, led0} <= bcd;
          digits_valid <= 1'b1;
          busy <= 1'b0;
          state <= ACC;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_adc_bcd_conv.sv
// tb_adc_bcd_conv: randomized self-checking bench for adc_bcd_conv against an arithmetic reference model.
module tb_adc_bcd_conv;
  localparam int AVG_LOG2 = 2;
  localparam int VREF = 3300;
`ifdef ADC_BCD_AVG_EN
  localparam int N = 1 << AVG_LOG2;
`else
  localparam int N = 1;
`endif
  logic clk = 1'b0, rst = 1'b1, sample_valid = 1'b0;
  logic [7:0] sample = '0;
  logic [3:0] led0, led1, led2, led3;
  logic digits_valid, busy, overrun;
  int total = 0, bad = 0;

  adc_bcd_conv #(.AVG_LOG2(AVG_LOG2), .VREF_MV(VREF)) dut (
    .clk(clk), .rst(rst), .sample(sample), .sample_valid(sample_valid),
    .led0(led0), .led1(led1), .led2(led2), .led3(led3),
    .digits_valid(digits_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int qsum(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  // millivolts from the window average, then decimal digits packed thousands..ones
  function automatic logic [15:0] model(input int sum);
    int mv;
    mv = (sum / N) * VREF / 256;
    return {4'(mv / 1000), 4'(mv / 100 % 10), 4'(mv / 10 % 10), 4'(mv % 10)};
  endfunction

  function automatic logic [15:0] leds();
    return {led3, led2, led1, led0};
  endfunction

  // leaves the bench 1 time unit after E0, the edge that took the last sample
  task automatic send_window(input int q[$]);
    for (int i = 0; i < q.size(); i++) begin
      sample = 8'(q[i]);
      sample_valid = 1'b1;
      tick;
      sample_valid = 1'b0;
      sample = 8'($urandom);
      if (i < q.size() - 1) tick;
    end
  endtask

  task automatic wait_result(input int from, output int lat, output logic [15:0] got);
    lat = -1;
    got = 'x;
    for (int k = from + 1; k <= from + 40; k++) begin
      tick;
      if (digits_valid) begin
        lat = k;
        got = leds();
        return;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    total++; if (leds() !== 16'h0) begin bad++; $display("FAIL reset_leds: got %h want 0000", leds()); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (digits_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", digits_valid); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_patterns;
    int q[$];
    int lat;
    logic [15:0] got, exp;
    for (int p = 0; p < 3; p++) begin
      q = {};
      for (int i = 0; i < N; i++) q.push_back(p == 0 ? 255 : p == 1 ? (i == N - 1 ? 129 : 128) : 0);
      exp = model(qsum(q));
      send_window(q);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL pat%0d_busy_e0: got %b want 1", p, busy); end
      wait_result(0, lat, got);
      total++; if (lat !== 14) begin bad++; $display("FAIL pat%0d_latency: got %0d want 14", p, lat); end
      total++; if (got !== exp) begin bad++; $display("FAIL pat%0d_digits: got %h want %h", p, got, exp); end
      if (p == 0) begin
        total++; if (got !== 16'h3287) begin bad++; $display("FAIL full_scale: got %h want 3287", got); end
      end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL pat%0d_busy_e14: got %b want 0", p, busy); end
      tick;
      total++; if (digits_valid !== 1'b0) begin bad++; $display("FAIL pat%0d_pulse_width: got %b want 0", p, digits_valid); end
      repeat (3) tick;
      total++; if (leds() !== exp) begin bad++; $display("FAIL pat%0d_hold: got %h want %h", p, leds(), exp); end
    end
  endtask

  task automatic test_random;
    int q[$];
    int lat;
    logic [15:0] got, exp;
    for (int w = 0; w < 8; w++) begin
      q = {};
      for (int i = 0; i < N; i++) q.push_back(int'($urandom_range(255)));
      exp = model(qsum(q));
      repeat ($urandom_range(3)) tick;
      send_window(q);
      wait_result(0, lat, got);
      total++; if (lat !== 14) begin bad++; $display("FAIL rand%0d_latency: got %0d want 14", w, lat); end
      total++; if (got !== exp) begin bad++; $display("FAIL rand%0d_digits: got %h want %h", w, got, exp); end
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rand%0d_overrun: got %b want 0", w, overrun); end
    end
  endtask

  task automatic test_overrun;
    int q[$], q2[$];
    int lat;
    logic [15:0] got;
    for (int i = 0; i < N; i++) q.push_back(int'($urandom_range(255)));
    for (int i = 0; i < N; i++) q2.push_back(int'($urandom_range(255)));
    tick;
    send_window(q);
    repeat (4) tick;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_quiet: got %b want 0", overrun); end
    sample = 8'hFF;
    sample_valid = 1'b1;
    tick;
    sample_valid = 1'b0;
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_pulse: got %b want 1", overrun); end
    tick;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_width: got %b want 0", overrun); end
    wait_result(6, lat, got);
    total++; if (lat !== 14) begin bad++; $display("FAIL ovr_latency: got %0d want 14", lat); end
    total++; if (got !== model(qsum(q))) begin bad++; $display("FAIL ovr_inflight: got %h want %h", got, model(qsum(q))); end
    tick;
    send_window(q2);
    wait_result(0, lat, got);
    total++; if (got !== model(qsum(q2))) begin bad++; $display("FAIL ovr_next_window: got %h want %h", got, model(qsum(q2))); end
  endtask

  task automatic test_back_to_back;
    int q[$], q2[$];
    int lat;
    logic [15:0] got;
    for (int i = 0; i < N; i++) q.push_back(int'($urandom_range(255)));
    for (int i = 0; i < N; i++) q2.push_back(int'($urandom_range(255)));
    tick;
    send_window(q);
    repeat (13) tick;
    total++; if (digits_valid !== 1'b0) begin bad++; $display("FAIL b2b_early_valid: got %b want 0", digits_valid); end
    sample = 8'hFF;
    sample_valid = 1'b1;
    tick;
    sample_valid = 1'b0;
    total++; if (digits_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid_e14: got %b want 1", digits_valid); end
    total++; if (leds() !== model(qsum(q))) begin bad++; $display("FAIL b2b_digits: got %h want %h", leds(), model(qsum(q))); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL b2b_e14_dropped: got %b want 1", overrun); end
    send_window(q2);
    wait_result(0, lat, got);
    total++; if (lat !== 14) begin bad++; $display("FAIL b2b_latency: got %0d want 14", lat); end
    total++; if (got !== model(qsum(q2))) begin bad++; $display("FAIL b2b_e15_window: got %h want %h", got, model(qsum(q2))); end
  endtask

  task automatic test_reset_mid;
    int q[$], q2[$];
    int lat, pulses;
    logic [15:0] got;
    for (int i = 0; i < N; i++) q.push_back(int'($urandom_range(1, 255)));
    for (int i = 0; i < N; i++) q2.push_back(int'($urandom_range(255)));
    tick;
    send_window(q);
    repeat (7) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    total++; if (leds() !== 16'h0) begin bad++; $display("FAIL rstmid_leds: got %h want 0000", leds()); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      if (digits_valid) pulses++;
      tick;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL rstmid_no_valid: got %0d pulses want 0", pulses); end
    for (int i = 0; i < N - 1; i++) begin
      sample = 8'hFF;
      sample_valid = 1'b1;
      tick;
      sample_valid = 1'b0;
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    send_window(q2);
    wait_result(0, lat, got);
    total++; if (lat !== 14) begin bad++; $display("FAIL rstmid_latency: got %0d want 14", lat); end
    total++; if (got !== model(qsum(q2))) begin bad++; $display("FAIL rstmid_after: got %h want %h", got, model(qsum(q2))); end
  endtask

  initial begin
    test_reset;
    test_patterns;
    test_random;
    test_overrun;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
